cacheline_adaptor: RTL and testbench

CACHELINE_ADAPTOR -- requirements
Module: cacheline_adaptor

---
 rtl/cacheline_pkg.sv | 18 +
 rtl/cacheline_adaptor.sv | 149 ++++++++++++++
 tb/tb_cacheline_adaptor.sv | 246 ++++++++++++++++++++++++
 3 files changed

// File: rtl/cacheline_pkg.sv
// Shared types and default geometry for the cache-line / memory-burst adaptor.
package cacheline_pkg;

  localparam int unsigned DefLineW    = 256;
  localparam int unsigned DefBeatW    = 64;
  localparam int unsigned DefBurstLen = DefLineW / DefBeatW;

  typedef logic [DefLineW-1:0] line_t;
  typedef logic [DefBeatW-1:0] beat_t;

  typedef enum logic [1:0] {
    StIdle,
    StRead,
    StWrite,
    StDone
  } state_e;

endpackage

// File: rtl/cacheline_adaptor.sv
// Converts single cache-line read/write requests into BURST_LEN-beat memory bursts.
// Optional watchdog enabled by defining CACHELINE_ADAPTOR_TIMEOUT_EN.
module cacheline_adaptor
  import cacheline_pkg::*;
#(
  parameter int unsigned LINE_W  = DefLineW,
  parameter int unsigned BEAT_W  = DefBeatW,
  parameter int unsigned ADDR_W  = 32,
  parameter int unsigned TIMEOUT = 1024
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              read_i,
  input  logic              write_i,
  input  logic [ADDR_W-1:0] address_i,
  input  logic [LINE_W-1:0] line_i,
  output logic [LINE_W-1:0] line_o,
  output logic              resp_o,
  output logic              read_o,
  output logic              write_o,
  output logic [ADDR_W-1:0] address_o,
  output logic [BEAT_W-1:0] burst_o,
  input  logic [BEAT_W-1:0] burst_i,
  input  logic              resp_i,
  output logic              err_o
);

  localparam int unsigned BurstLen = LINE_W / BEAT_W;
  localparam int unsigned CntW     = (BurstLen > 1) ? $clog2(BurstLen) : 1;
  localparam int unsigned OffW     = $clog2(LINE_W / 8);
  localparam logic [CntW-1:0]   LastBeat = CntW'(BurstLen - 1);
  localparam logic [ADDR_W-1:0] AddrMask = {ADDR_W{1'b1}} << OffW;

  state_e             state_q, state_d;
  logic [CntW-1:0]    cnt_q, cnt_d;
  logic [LINE_W-1:0]  line_q, line_d;
  logic [LINE_W-1:0]  wline_q, wline_d;
  logic [ADDR_W-1:0]  addr_q, addr_d;

`ifdef CACHELINE_ADAPTOR_TIMEOUT_EN
  localparam int unsigned ToW = $clog2(TIMEOUT + 1);
  logic [ToW-1:0] to_q, to_d;
  logic           err_q, err_d;
`endif

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    line_d  = line_q;
    wline_d = wline_q;
    addr_d  = addr_q;
    read_o  = 1'b0;
    write_o = 1'b0;
    resp_o  = 1'b0;

    unique case (state_q)
      StIdle: begin
        cnt_d = '0;
        if (write_i) begin
          addr_d  = address_i & AddrMask;
          wline_d = line_i;
          state_d = StWrite;
        end else if (read_i) begin
          addr_d  = address_i & AddrMask;
          state_d = StRead;
        end
      end
      StRead: begin
        read_o = 1'b1;
        if (resp_i) begin
          line_d[cnt_q*BEAT_W +: BEAT_W] = burst_i;
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == LastBeat) state_d = StDone;
        end
      end
      StWrite: begin
        write_o = 1'b1;
        if (resp_i) begin
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == LastBeat) state_d = StDone;
        end
      end
      StDone: begin
        // Requests are still high here; returning to idle without sampling them avoids a re-issue.
        resp_o  = 1'b1;
        cnt_d   = '0;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase

`ifdef CACHELINE_ADAPTOR_TIMEOUT_EN
    to_d  = to_q;
    err_d = err_q;
    if (state_q == StRead || state_q == StWrite) begin
      if (resp_i) begin
        to_d = '0;
      end else if (to_q == ToW'(TIMEOUT - 1)) begin
        to_d    = '0;
        err_d   = 1'b1;
        state_d = StDone;
      end else begin
        to_d = to_q + 1'b1;
      end
    end else begin
      to_d = '0;
    end
`endif
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      line_q  <= '0;
      wline_q <= '0;
      addr_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      line_q  <= line_d;
      wline_q <= wline_d;
      addr_q  <= addr_d;
    end
  end

`ifdef CACHELINE_ADAPTOR_TIMEOUT_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      to_q  <= '0;
      err_q <= 1'b0;
    end else begin
      to_q  <= to_d;
      err_q <= err_d;
    end
  end

  assign err_o = err_q;
`else
  logic unused_timeout;
  assign unused_timeout = ^TIMEOUT;
  assign err_o          = 1'b0;
`endif

  assign line_o    = line_q;
  assign address_o = addr_q;
  assign burst_o   = wline_q[cnt_q*BEAT_W +: BEAT_W];

endmodule

// File: tb/tb_cacheline_adaptor.sv
// Self-checking bench for cacheline_adaptor: directed vectors, corner sequences, random bursts.
module tb_cacheline_adaptor;

  typedef logic [255:0] line_t;

  localparam int unsigned Tmo = 16;

  logic        clk = 1'b0;
  logic        rst;
  logic        read_i, write_i, resp_i, resp_o, read_o, write_o, err_o;
  logic [31:0] address_i, address_o;
  line_t       line_i, line_o;
  logic [63:0] burst_o, burst_i;

  int    n_chk  = 0;
  int    n_pass = 0;
  line_t last_fill;

  always #5 clk = ~clk;

  cacheline_adaptor #(
    .LINE_W (256),
    .BEAT_W (64),
    .ADDR_W (32),
    .TIMEOUT(Tmo)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .read_i   (read_i),
    .write_i  (write_i),
    .address_i(address_i),
    .line_i   (line_i),
    .line_o   (line_o),
    .resp_o   (resp_o),
    .read_o   (read_o),
    .write_o  (write_o),
    .address_o(address_o),
    .burst_o  (burst_o),
    .burst_i  (burst_i),
    .resp_i   (resp_i),
    .err_o    (err_o)
  );

  typedef struct {
    bit          wr;
    bit          rd;
    logic [31:0] addr;
    line_t       data;
    int          stall_at;
    int          stall_len;
    int          exp_lat;
    logic [31:0] exp_addr;
  } vec_t;

  vec_t vecs[4];

  task automatic check(input string name, input line_t act, input line_t exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  // Memory side: resp_i high every cycle except stall_len cycles inserted before beat stall_at.
  task automatic do_txn(input bit wr, input bit rd, input logic [31:0] addr, input line_t data,
                        input int stall_at, input int stall_len,
                        output int lat, output line_t wbeats, output bit lvl_ok);
    int beat, stall_left;
    lvl_ok = 1'b1;
    wbeats = '0;
    beat = 0;
    stall_left = stall_len;
    lat = -1;
    @(negedge clk);
    write_i = wr;
    read_i = rd;
    address_i = addr;
    line_i = data;
    resp_i = 1'b0;
    @(posedge clk);
    for (int cyc = 1; cyc <= 200 && lat < 0; cyc++) begin
      @(negedge clk);
      if (resp_o) begin
        lat = cyc;
        resp_i = 1'b0;
        if (read_o || write_o) lvl_ok = 1'b0;
      end else begin
        if (write_o !== wr || read_o !== (rd && !wr)) lvl_ok = 1'b0;
        if (beat >= 4 || (beat == stall_at && stall_left > 0)) begin
          resp_i = 1'b0;
          burst_i = {$urandom, $urandom};
          if (stall_left > 0 && beat == stall_at) stall_left--;
        end else begin
          resp_i = 1'b1;
          burst_i = data[beat*64 +: 64];
          if (wr) wbeats[beat*64 +: 64] = burst_o;
          beat++;
        end
      end
    end
    // Request still held in the completion cycle; the DUT must not start a second burst.
    @(negedge clk);
    if (read_o || write_o || resp_o) lvl_ok = 1'b0;
    read_i = 1'b0;
    write_i = 1'b0;
    @(negedge clk);
    if (read_o || write_o || resp_o) lvl_ok = 1'b0;
  endtask

  task automatic run_and_check(input string tag, input bit wr, input bit rd,
                               input logic [31:0] addr, input line_t data,
                               input int stall_at, input int stall_len,
                               input int exp_lat, input logic [31:0] exp_addr);
    int    lat;
    line_t wb;
    bit    lvl;
    do_txn(wr, rd, addr, data, stall_at, stall_len, lat, wb, lvl);
    check($sformatf("%s latency", tag), line_t'(lat), line_t'(exp_lat));
    check($sformatf("%s address_o", tag), line_t'(address_o), line_t'(exp_addr));
    check($sformatf("%s req levels", tag), line_t'(lvl), line_t'(1));
    if (wr) begin
      check($sformatf("%s write beats", tag), wb, data);
      check($sformatf("%s line_o held", tag), line_o, last_fill);
      check($sformatf("%s burst_o idle", tag), line_t'(burst_o), line_t'(data[63:0]));
    end else begin
      check($sformatf("%s line_o fill", tag), line_o, data);
      last_fill = data;
    end
  endtask

  initial begin
    rst = 1'b0;
    read_i = 1'b0;
    write_i = 1'b0;
    resp_i = 1'b0;
    address_i = '0;
    line_i = '0;
    burst_i = '0;
    last_fill = '0;

    vecs[0] = '{1'b0, 1'b1, 32'h0000_1000, {64'hA3, 64'hA2, 64'hA1, 64'hA0}, 99, 0, 5,
                32'h0000_1000};
    vecs[1] = '{1'b1, 1'b0, 32'h1234_567F, {64'hD3, 64'hD2, 64'hD1, 64'hD0}, 99, 0, 5,
                32'h1234_5660};
    vecs[2] = '{1'b0, 1'b1, 32'hFFFF_FFFF, {64'hB3, 64'hB2, 64'hB1, 64'hB0}, 2, 3, 8,
                32'hFFFF_FFE0};
    vecs[3] = '{1'b1, 1'b1, 32'h0000_003F, {64'hC3, 64'hC2, 64'hC1, 64'hC0}, 99, 0, 5,
                32'h0000_0020};

    #12;
    check("reset read_o", line_t'(read_o), '0);
    check("reset write_o", line_t'(write_o), '0);
    check("reset resp_o", line_t'(resp_o), '0);
    check("reset err_o", line_t'(err_o), '0);
    check("reset line_o", line_o, '0);
    check("reset address_o", line_t'(address_o), '0);
    @(negedge clk);
    rst = 1'b1;

    foreach (vecs[i]) begin
      run_and_check($sformatf("vec%0d", i), vecs[i].wr, vecs[i].rd, vecs[i].addr, vecs[i].data,
                    vecs[i].stall_at, vecs[i].stall_len, vecs[i].exp_lat, vecs[i].exp_addr);
    end

    // Reset asserted while beat 2 of a write-back is on the bus.
    @(negedge clk);
    write_i = 1'b1;
    address_i = 32'h0000_4444;
    line_i = {64'hE3, 64'hE2, 64'hE1, 64'hE0};
    @(posedge clk);
    for (int b = 0; b < 3; b++) begin
      @(negedge clk);
      resp_i = 1'b1;
    end
    #2 rst = 1'b0;
    #1;
    check("abort write_o", line_t'(write_o), '0);
    check("abort resp_o", line_t'(resp_o), '0);
    check("abort line_o", line_o, '0);
    write_i = 1'b0;
    resp_i = 1'b0;
    @(negedge clk);
    check("abort resp_o later", line_t'(resp_o), '0);
    rst = 1'b1;
    last_fill = '0;
    run_and_check("post-abort", 1'b0, 1'b1, 32'h0000_8001, {64'h13, 64'h12, 64'h11, 64'h10},
                  99, 0, 5, 32'h0000_8000);

    // Random traffic against the burst-level model.
    for (int n = 0; n < 20; n++) begin
      bit          wr, rd;
      int          s_at, s_len;
      logic [31:0] a;
      line_t       d;
      wr = 1'($urandom_range(0, 1));
      rd = wr ? 1'($urandom_range(0, 1)) : 1'b1;
      s_at = $urandom_range(0, 3);
      s_len = $urandom_range(0, 4);
      a = $urandom;
      for (int k = 0; k < 8; k++) d[k*32 +: 32] = $urandom;
      run_and_check($sformatf("rnd%0d", n), wr, rd, a, d, s_at, s_len, 5 + s_len,
                    a & 32'hFFFF_FFE0);
    end

    // Memory never answers.
`ifdef CACHELINE_ADAPTOR_TIMEOUT_EN
    begin
      int    lat;
      line_t wb;
      bit    lvl;
      do_txn(1'b0, 1'b1, 32'h0000_0100, '0, 0, 1000, lat, wb, lvl);
      check("timeout latency", line_t'(lat), line_t'(Tmo + 1));
      check("timeout levels", line_t'(lvl), line_t'(1));
      check("timeout err_o sticky", line_t'(err_o), line_t'(1));
      @(negedge clk);
      rst = 1'b0;
      #1;
      check("timeout err_o cleared", line_t'(err_o), '0);
      @(negedge clk);
      rst = 1'b1;
    end
`else
    begin
      bit seen;
      seen = 1'b0;
      @(negedge clk);
      read_i = 1'b1;
      resp_i = 1'b0;
      repeat (Tmo * 3) begin
        @(negedge clk);
        if (resp_o) seen = 1'b1;
      end
      check("no-timeout resp_o", line_t'(seen), '0);
      check("no-timeout err_o", line_t'(err_o), '0);
      check("no-timeout read_o", line_t'(read_o), line_t'(1));
      read_i = 1'b0;
      rst = 1'b0;
      @(negedge clk);
      rst = 1'b1;
    end
`endif

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
